// File: rtl/frame_tracker.sv
// Per-frame beat tracker for an AXI-Stream link: classifies each frame as good, runt or
// oversize, emits one-cycle event pulses and keeps saturating good/errored frame counts.
module frame_tracker #(
    parameter int HDR_BEATS = 2,
    parameter int MAX_BEATS = 190,
    parameter int CNT_W     = 16,
    parameter int STAT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              beat_accept,
    input  logic              tlast,
    input  logic              soft_clr,
    output logic              frame_start,
    output logic              frame_end,
    output logic              in_header,
    output logic              in_payload,
    output logic              in_drop,
    output logic [CNT_W-1:0]  beat_idx,
    output logic              err_runt,
    output logic              err_oversize,
    output logic [STAT_W-1:0] frames_ok,
    output logic [STAT_W-1:0] frames_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DROP    = 2'd3
    } state_t;

    // With a single header beat the first beat already completes the header.
    localparam state_t FIRST_NEXT = (HDR_BEATS > 1) ? ST_HEADER : ST_PAYLOAD;

    state_t            r_state;
    logic [CNT_W-1:0]  r_beat_idx;
    logic              r_frame_start;
    logic              r_frame_end;
    logic              r_err_runt;
    logic              r_err_oversize;
    logic [STAT_W-1:0] r_frames_ok;
    logic [STAT_W-1:0] r_frames_err;

    logic w_at_max;
    logic w_hdr_last;
    logic w_good;
    logic w_bad;

    assign w_at_max   = (r_beat_idx == CNT_W'(MAX_BEATS));
    assign w_hdr_last = (r_beat_idx == CNT_W'(HDR_BEATS - 1));

    // Classify the beat being accepted this cycle as closing a good or an errored frame.
    always_comb begin
        w_good = 1'b0;
        w_bad  = 1'b0;
        if (beat_accept) begin
            case (r_state)
                ST_IDLE, ST_HEADER: begin
                    w_bad = tlast;
                end
                ST_PAYLOAD: begin
                    if (w_at_max) begin
                        w_bad = 1'b1;
                    end else begin
                        w_good = tlast;
                    end
                end
                default: begin
                    w_good = 1'b0;
                    w_bad  = 1'b0;
                end
            endcase
        end else begin
            w_good = 1'b0;
            w_bad  = 1'b0;
        end
    end

    // Frame state machine, beat index and one-cycle event pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_beat_idx     <= {CNT_W{1'b0}};
            r_frame_start  <= 1'b0;
            r_frame_end    <= 1'b0;
            r_err_runt     <= 1'b0;
            r_err_oversize <= 1'b0;
        end else begin
            r_frame_start  <= 1'b0;
            r_frame_end    <= 1'b0;
            r_err_runt     <= 1'b0;
            r_err_oversize <= 1'b0;
            if (beat_accept) begin
                case (r_state)
                    ST_IDLE: begin
                        r_frame_start <= 1'b1;
                        if (tlast) begin
                            r_frame_end <= 1'b1;
                            r_err_runt  <= 1'b1;
                            r_beat_idx  <= {CNT_W{1'b0}};
                            r_state     <= ST_IDLE;
                        end else begin
                            r_beat_idx  <= CNT_W'(1);
                            r_state     <= FIRST_NEXT;
                        end
                    end
                    ST_HEADER: begin
                        if (tlast) begin
                            r_frame_end <= 1'b1;
                            r_err_runt  <= 1'b1;
                            r_beat_idx  <= {CNT_W{1'b0}};
                            r_state     <= ST_IDLE;
                        end else begin
                            r_beat_idx  <= r_beat_idx + CNT_W'(1);
                            r_state     <= w_hdr_last ? ST_PAYLOAD : ST_HEADER;
                        end
                    end
                    ST_PAYLOAD: begin
                        // Beat MAX_BEATS is one too many; the index parks there while dropping.
                        if (w_at_max) begin
                            r_err_oversize <= 1'b1;
                            if (tlast) begin
                                r_frame_end <= 1'b1;
                                r_beat_idx  <= {CNT_W{1'b0}};
                                r_state     <= ST_IDLE;
                            end else begin
                                r_state     <= ST_DROP;
                            end
                        end else if (tlast) begin
                            r_frame_end <= 1'b1;
                            r_beat_idx  <= {CNT_W{1'b0}};
                            r_state     <= ST_IDLE;
                        end else begin
                            r_beat_idx  <= r_beat_idx + CNT_W'(1);
                        end
                    end
                    ST_DROP: begin
                        if (tlast) begin
                            r_frame_end <= 1'b1;
                            r_beat_idx  <= {CNT_W{1'b0}};
                            r_state     <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_beat_idx <= {CNT_W{1'b0}};
                        r_state    <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Saturating frame statistics; a coincident soft clear beats an increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frames_ok  <= {STAT_W{1'b0}};
            r_frames_err <= {STAT_W{1'b0}};
        end else if (soft_clr) begin
            r_frames_ok  <= {STAT_W{1'b0}};
            r_frames_err <= {STAT_W{1'b0}};
        end else begin
            if (w_good && (r_frames_ok != {STAT_W{1'b1}})) begin
                r_frames_ok <= r_frames_ok + STAT_W'(1);
            end
            if (w_bad && (r_frames_err != {STAT_W{1'b1}})) begin
                r_frames_err <= r_frames_err + STAT_W'(1);
            end
        end
    end

    assign frame_start  = r_frame_start;
    assign frame_end    = r_frame_end;
    assign err_runt     = r_err_runt;
    assign err_oversize = r_err_oversize;
    assign beat_idx     = r_beat_idx;
    assign frames_ok    = r_frames_ok;
    assign frames_err   = r_frames_err;
    assign in_header    = (r_state == ST_HEADER);
    assign in_payload   = (r_state == ST_PAYLOAD);
    assign in_drop      = (r_state == ST_DROP);

endmodule

// File: tb/tb_frame_tracker.sv
// Bench for frame_tracker with HDR_BEATS=2, MAX_BEATS=8, STAT_W=2: a table of per-beat
// vectors run through a scoreboard queue, plus a hand-driven asynchronous reset sequence.
module tb_frame_tracker;

    logic        clk;
    logic        rst_n;
    logic        beat_accept;
    logic        tlast;
    logic        soft_clr;
    logic        frame_start;
    logic        frame_end;
    logic        in_header;
    logic        in_payload;
    logic        in_drop;
    logic [15:0] beat_idx;
    logic        err_runt;
    logic        err_oversize;
    logic [1:0]  frames_ok;
    logic [1:0]  frames_err;

    typedef struct packed {
        logic        fs;
        logic        fe;
        logic        ih;
        logic        ip;
        logic        id;
        logic [15:0] idx;
        logic        er;
        logic        eo;
        logic [1:0]  ok;
        logic [1:0]  err;
    } out_t;

    typedef struct packed {
        logic acc;
        logic tl;
        logic clr;
        out_t exp;
    } vec_t;

    vec_t tbl[$];
    out_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    frame_tracker #(
        .HDR_BEATS(2),
        .MAX_BEATS(8),
        .CNT_W(16),
        .STAT_W(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .beat_accept(beat_accept),
        .tlast(tlast),
        .soft_clr(soft_clr),
        .frame_start(frame_start),
        .frame_end(frame_end),
        .in_header(in_header),
        .in_payload(in_payload),
        .in_drop(in_drop),
        .beat_idx(beat_idx),
        .err_runt(err_runt),
        .err_oversize(err_oversize),
        .frames_ok(frames_ok),
        .frames_err(frames_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic acc, input logic tl, input logic clr,
                                input logic fs, input logic fe, input logic ih,
                                input logic ip, input logic id, input int idx,
                                input logic er, input logic eo, input int ok, input int err);
        vec_t v;
        v.acc     = acc;
        v.tl      = tl;
        v.clr     = clr;
        v.exp.fs  = fs;
        v.exp.fe  = fe;
        v.exp.ih  = ih;
        v.exp.ip  = ip;
        v.exp.id  = id;
        v.exp.idx = 16'(idx);
        v.exp.er  = er;
        v.exp.eo  = eo;
        v.exp.ok  = 2'(ok);
        v.exp.err = 2'(err);
        return v;
    endfunction

    function automatic string fmt(input out_t o);
        return $sformatf("fs=%b fe=%b hdr=%b pay=%b drop=%b idx=%0d runt=%b over=%b ok=%0d err=%0d",
                         o.fs, o.fe, o.ih, o.ip, o.id, o.idx, o.er, o.eo, o.ok, o.err);
    endfunction

    task automatic check(input string nm, input out_t e);
        out_t a;
        a.fs  = frame_start;
        a.fe  = frame_end;
        a.ih  = in_header;
        a.ip  = in_payload;
        a.id  = in_drop;
        a.idx = beat_idx;
        a.er  = err_runt;
        a.eo  = err_oversize;
        a.ok  = frames_ok;
        a.err = frames_err;
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got {%s} want {%s}", nm, fmt(a), fmt(e));
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, compare once the edge has passed.
    task automatic step(input string nm, input vec_t v);
        @(negedge clk);
        beat_accept = v.acc;
        tlast       = v.tl;
        soft_clr    = v.clr;
        sb.push_back(v.exp);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scoreboard empty, got 0 entries want 1", nm);
        end else begin
            check(nm, sb.pop_front());
        end
    endtask

    initial begin
        int okb;
        int oka;
        rst_n       = 1'b0;
        beat_accept = 1'b0;
        tlast       = 1'b0;
        soft_clr    = 1'b0;

        // 5-beat good frame with an idle cycle in the payload
        tbl.push_back(mk(1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 4, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        // 2-beat runt, then 1-beat runt
        tbl.push_back(mk(1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 1));
        tbl.push_back(mk(1, 1, 0, 1, 1, 0, 0, 0, 0, 1, 0, 1, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2));
        // 12-beat oversize frame
        tbl.push_back(mk(1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 1, 2));
        for (int k = 1; k <= 7; k++) tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, k + 1, 0, 0, 1, 2));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 8, 0, 1, 1, 3));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 8, 0, 0, 1, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 8, 0, 0, 1, 3));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 8, 0, 0, 1, 3));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 3));
        // 9-beat frame ending exactly on the oversize beat; error count already saturated
        tbl.push_back(mk(1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 1, 3));
        for (int k = 1; k <= 7; k++) tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, k + 1, 0, 0, 1, 3));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 3));
        // Soft clear while idle
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Six 3-beat good frames: counter saturates at 3, clear wins on the sixth end
        for (int f = 0; f < 6; f++) begin
            okb = (f < 3) ? f : 3;
            oka = (f == 5) ? 0 : ((f + 1 < 3) ? f + 1 : 3);
            tbl.push_back(mk(1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0, okb, 0));
            tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, okb, 0));
            tbl.push_back(mk(1, 1, (f == 5) ? 1'b1 : 1'b0, 0, 1, 0, 0, 0, 0, 0, 0, oka, 0));
        end

        repeat (2) @(negedge clk);
        check("in_reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0).exp);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("after_reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0).exp);

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i]);
        end

        // Asynchronous reset in the middle of a payload
        step("pre_good0", mk(1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0));
        step("pre_good1", mk(1, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0));
        step("pre_good2", mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        step("mid_b0", mk(1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 1, 0));
        step("mid_b1", mk(1, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 1, 0));
        step("mid_b2", mk(1, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 1, 0));
        @(negedge clk);
        beat_accept = 1'b1;
        tlast       = 1'b0;
        soft_clr    = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0).exp);
        @(negedge clk);
        beat_accept = 1'b0;
        rst_n       = 1'b1;
        step("post_reset_b0", mk(1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0));
        step("post_reset_b1", mk(1, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0));

        @(negedge clk);
        beat_accept = 1'b0;
        tlast       = 1'b0;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/frame_tracker.md
FRAME_TRACKER -- requirements
Module: frame_tracker

Interface
REQ-001 SHALL have parameter HDR_BEATS, default 2, number of header beats per frame (>=1).
REQ-002 SHALL have parameter MAX_BEATS, default 190, maximum legal frame length in beats (MAX_BEATS > HDR_BEATS, MAX_BEATS < 2**CNT_W).
REQ-003 SHALL have parameter CNT_W, default 16, width of the beat index.
REQ-004 SHALL have parameter STAT_W, default 16, width of the statistics counters.
REQ-005 clk  input  1  clock; all flops rising-edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 beat_accept  input  1  AXI-Stream beat accepted (tvalid && tready).
REQ-008 tlast  input  1  last beat of frame; qualified by beat_accept.
REQ-009 soft_clr  input  1  synchronous clear of frames_ok/frames_err.
REQ-010 frame_start  output  1  one-cycle pulse: first beat of a frame accepted.
REQ-011 frame_end  output  1  one-cycle pulse: terminating beat of a frame accepted, good or errored.
REQ-012 in_header / in_payload / in_drop  output  1 each  state decodes.
REQ-013 beat_idx  output  CNT_W  beats accepted so far in current frame.
REQ-014 err_runt / err_oversize  output  1 each  one-cycle error pulses.
REQ-015 frames_ok / frames_err  output  STAT_W each  saturating frame counters.

Function
REQ-016 SHALL implement states IDLE, HEADER, PAYLOAD, DROP; state changes only on edges where beat_accept=1; beat_accept=0 holds every register except pulse outputs.
REQ-017 Beat index k = beat_idx value at acceptance (0 = first beat of frame).
REQ-018 IDLE, accept, tlast=0: to HEADER if HDR_BEATS>1, else to PAYLOAD.
REQ-019 HEADER, accept of beat k=HDR_BEATS-1 with tlast=0: to PAYLOAD; k<HDR_BEATS-1 with tlast=0: stay HEADER.
REQ-020 Runt: tlast=1 accepted in IDLE or HEADER: to IDLE; err_runt pulse.
REQ-021 PAYLOAD, accept with tlast=1 and k<MAX_BEATS: to IDLE; good frame.
REQ-022 Oversize: accept of beat k=MAX_BEATS in PAYLOAD: err_oversize pulse; tlast=1 -> IDLE, tlast=0 -> DROP.
REQ-023 DROP: stay until tlast=1 accepted, then IDLE; no further err_oversize pulses.
REQ-024 beat_idx increments per accepted beat; saturates at MAX_BEATS (held throughout DROP); 0 on the cycle after any frame-terminating beat.
REQ-025 in_header=(state==HEADER), in_payload=(state==PAYLOAD), in_drop=(state==DROP); decoded directly from the state register, mutually exclusive.
REQ-026 frame_start, frame_end, err_runt, err_oversize SHALL be registered, high exactly one cycle, in the cycle after the accepting edge.
REQ-027 A 1-beat frame (accept in IDLE with tlast=1) SHALL pulse frame_start, frame_end and err_runt in the same cycle.
REQ-028 frames_ok increments on each good frame; frames_err increments once per runt or oversize frame; both saturate at all-ones.
REQ-029 soft_clr zeroes both counters next edge; soft_clr wins over a coincident increment.
REQ-030 Illegal state encoding SHALL recover to IDLE on the next edge.

Reset
REQ-031 rst_n=0 SHALL immediately force state=IDLE, beat_idx=0, all pulses=0, in_* =0, frames_ok=frames_err=0, including mid-frame; beats after release start a new frame at k=0.

Verification (HDR_BEATS=2, MAX_BEATS=8, STAT_W=2)
REQ-032 5-beat frame, tlast on beat 4, one idle cycle inserted mid-payload -> frame_start after beat 0, in_header 1 cycle, in_payload until beat 4, frame_end after beat 4, frames_ok=1, beat_idx=0.
REQ-033 2-beat frame, tlast on beat 1 -> err_runt+frame_end same cycle, frames_err=1, state IDLE; 1-beat frame -> frame_start, frame_end and err_runt coincident.
REQ-034 12-beat frame -> err_oversize once after beat 8, in_drop beats 9..11, beat_idx held 8, frame_end after beat 11, frames_err+1.
REQ-035 9-beat frame, tlast on beat 8 -> err_oversize and frame_end coincident, DROP never entered.
REQ-036 5 good frames -> frames_ok=3 (saturated); soft_clr coincident with 6th frame end -> frames_ok=0.
REQ-037 rst_n low at payload beat 3 -> all outputs 0 asynchronously; next accepted beat gives frame_start, beat_idx=1.
